fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. It generates the program counter and issues word-aligned read requests to instruction memory. It buffers the returned words in a small in-order queue and presents one 32-bit instruction, with its PC, to the decoder through a valid/ready handshake. Branch and jump redirects from execute flush the queue and discard in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 64 ++++++
 rtl/fetch_unit_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch stage.
//   XLEN             - architectural word width (32)
//   INSTR_BYTES      - PC increment per fetched instruction word
//   DEFAULT_RESET_PC - first fetch address after reset, shared with the core top
//   fetch_state_e    - fetch FSM states {FETCH, DRAIN}
//   word_align()     - clears the byte-offset bits of an address
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch stage and its neighbours.
//   imem_req_*     - read request to instruction memory (addr is word aligned)
//   imem_rsp_*     - in-order read data, no back-pressure
//   instr_*        - instruction + PC presented to the decoder
//   redirect_*     - branch/jump redirect pulse from execute
//   fetch_misaligned - only when FETCH_MISALIGN_CHECK_EN is defined
// Modports: master = fetch unit side, slave = memory/decoder/execute side.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clock edge where both valid and ready are high; valid never depends
// combinationally on ready. imem_rsp_valid has no ready and is always taken.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] instr_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            fetch_misaligned;
`endif

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instruction,
        output instr_pc,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
        , output fetch_misaligned
`endif
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instruction,
        input  instr_pc,
        output instr_ready,
        output redirect_valid,
        output redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
        , input fetch_misaligned
`endif
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with registered storage and flush.
//   clk, rst_n      - clock, synchronous active-low reset
//   flush           - empties the FIFO; overrides push and pop
//   push, push_data - write one entry
//   pop, pop_data   - pop_data is the head entry, valid when !empty
//   full, empty, count
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;

    // Push into a full FIFO is only legal together with a pop.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the decoder.
//   clk, rst_n  - clock, synchronous active-low reset
//   bus         - fetch_unit_if.master: imem request/response, decoder
//                 instruction handshake, execute redirect
//   fetch_state - current FSM state, for observation
// Parameters: RESET_PC (first fetch address), FIFO_DEPTH (power of two, >=2).
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds bus.fetch_misaligned,
// a one-cycle pulse after a redirect whose target has bits [1:0] set.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output fetch_state_e fetch_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, rsp_pc_q;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    in_use;
    logic              req_valid, req_fire, rsp_drop;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*XLEN-1:0] fifo_head;
    logic [XLEN-1:0]   redirect_target;

    assign redirect_target = word_align(bus.redirect_pc);

    always_comb begin
        in_use        = {1'b0, outstanding_q} + {1'b0, fifo_count};
        // Requests in flight plus queued words never exceed the FIFO depth,
        // so every response is guaranteed a slot. rst_n keeps the request
        // low while reset is held.
        req_valid     = rst_n && (state_q == FETCH) && (in_use < (CNT_W+1)'(FIFO_DEPTH));
        req_fire      = req_valid && bus.imem_req_ready;
        rsp_drop      = bus.imem_rsp_valid && (bus.redirect_valid || (discard_q != '0));
        fifo_push     = bus.imem_rsp_valid && !rsp_drop;
        fifo_pop      = !fifo_empty && bus.instr_ready && !bus.redirect_valid;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
        discard_d     = discard_q;
        state_d       = state_q;
        if (bus.redirect_valid) begin
            // Everything still in flight after this edge belongs to the old
            // path: that is exactly the next outstanding count.
            discard_d = outstanding_d;
            state_d   = (outstanding_d != '0) ? DRAIN : FETCH;
        end else begin
            if (bus.imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if ((state_q == DRAIN) && (discard_d == '0)) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (bus.redirect_valid) begin
                fetch_pc_q <= redirect_target;
                rsp_pc_q   <= redirect_target;
            end else begin
                if (req_fire) begin
                    fetch_pc_q <= fetch_pc_q + INSTR_BYTES;
                end
                if (fifo_push) begin
                    rsp_pc_q <= rsp_pc_q + INSTR_BYTES;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_valid),
        .push      (fifo_push),
        .push_data ({rsp_pc_q, bus.imem_rsp_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = !fifo_empty;
    assign bus.instruction    = fifo_head[XLEN-1:0];
    assign bus.instr_pc       = fifo_head[2*XLEN-1:XLEN];
    assign fetch_state        = state_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    assign bus.fetch_misaligned = misaligned_q;
`endif

    // A full queue leaves no credit for a new request.
    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_full && req_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Memory returns word = addr ^ 32'hA5A5_0000. Every request is tagged with
// the redirect epoch it was issued in; only responses from the current epoch
// (and not arriving with a redirect) are expected at the decoder.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_state_e fetch_state;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .fetch_state (fetch_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] pend_addr[$];
    int          pend_epoch[$];
    logic [63:0] exp_q[$];
    logic [31:0] m_fetch_pc;
    int          epoch;
    logic        m_mis_prev;

    // Values sampled in the latest cycle
    logic        s_req_valid, s_instr_valid, s_fired;
    logic [31:0] s_req_addr, s_instr_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has_stale();
        foreach (pend_epoch[i]) begin
            if (pend_epoch[i] != epoch) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        pend_addr.delete();
        pend_epoch.delete();
        exp_q.delete();
        m_fetch_pc = 32'h0;
        epoch      = 0;
        m_mis_prev = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instruction", bus.instruction, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_state_drain", fetch_state == DRAIN, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misaligned", bus.fetch_misaligned, 0);
`endif
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs,
    // then advance the model for the upcoming rising edge.
    task automatic do_cycle(input logic rr, input logic ir, input logic redir,
                            input logic [31:0] rpc, input int rsp_pct);
        logic        rv;
        logic [31:0] raddr;
        int          rep;
        logic        exp_rv, exp_drain;
        @(negedge clk);
        exp_drain = has_stale();
        exp_rv    = !exp_drain && ((pend_addr.size() + exp_q.size()) < DEPTH);
        rv = 1'b0;
        raddr = '0;
        rep = 0;
        if (pend_addr.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
            rv    = 1'b1;
            raddr = pend_addr.pop_front();
            rep   = pend_epoch.pop_front();
        end
        bus.imem_req_ready = rr;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rv ? (raddr ^ KEY) : $urandom;
        bus.instr_ready    = ir;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        s_req_valid   = bus.imem_req_valid;
        s_req_addr    = bus.imem_req_addr;
        s_instr_valid = bus.instr_valid;
        s_instr_pc    = bus.instr_pc;
        check("req_valid", s_req_valid, exp_rv);
        if (s_req_valid && exp_rv) check("req_addr", s_req_addr, m_fetch_pc);
        check("instr_valid", s_instr_valid, exp_q.size() > 0);
        if (s_instr_valid && exp_q.size() > 0) begin
            check("instr_pc", s_instr_pc, exp_q[0][63:32]);
            check("instruction", bus.instruction, exp_q[0][31:0]);
        end
        check("state_drain", fetch_state == DRAIN, exp_drain);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misaligned", bus.fetch_misaligned, m_mis_prev);
`endif
        s_fired = s_req_valid && rr;
        if (s_fired) begin
            pend_addr.push_back(s_req_addr);
            pend_epoch.push_back(epoch);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (exp_q.size() > 0 && ir && !redir) void'(exp_q.pop_front());
        if (rv && !redir && rep == epoch) exp_q.push_back({raddr, raddr ^ KEY});
        if (redir) begin
            exp_q.delete();
            epoch++;
            m_fetch_pc = rpc & ~32'd3;
        end
        m_mis_prev = redir && (rpc[1:0] != 2'b00);
    endtask

    typedef struct {
        logic        rr;
        logic        ir;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_instr_valid;
        logic [31:0] exp_instr_pc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          got, seen;
        logic [31:0] first_pc;

        // Zero-wait memory, decoder always ready: credit of 2 gives the
        // pattern below straight out of reset.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        do_reset();
        foreach (vecs[i]) begin
            do_cycle(vecs[i].rr, vecs[i].ir, 1'b0, 32'h0, 100);
            check("vec_req_valid", s_req_valid, vecs[i].exp_req_valid);
            if (vecs[i].exp_req_valid) check("vec_req_addr", s_req_addr, vecs[i].exp_req_addr);
            check("vec_instr_valid", s_instr_valid, vecs[i].exp_instr_valid);
            if (vecs[i].exp_instr_valid) check("vec_instr_pc", s_instr_pc, vecs[i].exp_instr_pc);
        end

        // Decoder stalls: requests stop once credit is used up.
        n = 0;
        repeat (10) begin
            do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 100);
            if (s_fired) n++;
        end
        check("stall_req_count_le2", n <= 2, 1);
        check("stall_req_valid_off", s_req_valid, 0);
        check("stall_instr_held", s_instr_valid, 1);
        repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 100);

        // Redirect to 0x100 with two requests outstanding.
        for (int i = 0; i < 20 && pend_addr.size() < 2; i++) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
        check("setup_two_outstanding", pend_addr.size(), 2);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h100, 0);
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
        check("redirect_in_drain", fetch_state == DRAIN, 1);
        got = 0;
        first_pc = '0;
        for (int i = 0; i < 30; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 100);
            if (s_instr_valid) begin got = 1; first_pc = s_instr_pc; break; end
        end
        check("redirect_delivered", got, 1);
        check("redirect_first_pc", first_pc, 32'h100);

        // Redirect coinciding with a response and a request handshake.
        for (int i = 0; i < 30 && (pend_addr.size() > 0 || exp_q.size() > 0); i++)
            do_cycle(1'b0, 1'b1, 1'b0, 32'h0, 100);
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
        check("coincide_one_pending", pend_addr.size(), 1);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h300, 100);
        check("coincide_req_fired", s_fired, 1);
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 0);
        check("coincide_in_drain", fetch_state == DRAIN, 1);
        check("coincide_no_stale", s_instr_valid, 0);
        got = 0;
        first_pc = '0;
        for (int i = 0; i < 30; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 100);
            if (s_instr_valid) begin got = 1; first_pc = s_instr_pc; break; end
        end
        check("coincide_delivered", got, 1);
        check("coincide_first_pc", first_pc, 32'h300);

        // Address wrap at the top of memory.
        do_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 100);
        seen = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 100);
            if (s_fired && seen) begin
                check("wrap_next_addr", s_req_addr, 32'h0);
                got = 1;
            end else if (s_fired && s_req_addr == 32'hFFFF_FFFC) begin
                seen = 1;
            end
        end
        check("wrap_observed", got, 1);

        // Misaligned redirect target: bits [1:0] cleared.
        do_cycle(1'b1, 1'b1, 1'b1, 32'h202, 100);
        seen = 0;
        first_pc = '0;
        for (int i = 0; i < 40; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 100);
`ifdef FETCH_MISALIGN_CHECK_EN
            if (i == 0) check("misalign_pulse", bus.fetch_misaligned, 1);
            if (i == 1) check("misalign_once", bus.fetch_misaligned, 0);
`endif
            if (s_fired && !seen) begin seen = 1; first_pc = s_req_addr; end
            if (seen && i >= 1) break;
        end
        check("misalign_seen_req", seen, 1);
        check("misalign_addr", first_pc, 32'h200);

        // Randomized traffic with redirects.
        repeat (400) begin
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 29) == 0, $urandom, 60);
        end

        // Reset in the middle of traffic, then resume.
        do_reset();
        repeat (120) begin
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 29) == 0, $urandom, 60);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
